// File: rtl/rename_rob_pkg.sv
// Shared types and sizing for the rename reorder buffer.
// Contents: physical register id type, ROB tag and occupancy types,
//           the per-entry record, and the fixed ROB depth.
// Latency / backpressure: not applicable (types only).
package rob_pkg;

  // 16-entry physical register pool in the renamer
  localparam int PREG_W    = 4;
  // Power of two, >= 2; tags wrap naturally because of this
  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = $clog2(ROB_DEPTH);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [TAG_W-1:0]  rob_tag_t;
  // One extra bit so a full ROB (count == ROB_DEPTH) is representable
  typedef logic [TAG_W:0]    rob_cnt_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    preg_t old_preg;
    preg_t new_preg;
  } rob_entry_t;

endpackage

// File: rtl/rename_rob_if.sv
// Handshake bundle between the renamer / execution side and the ROB.
// master: drives alloc and completion, observes ready, tag, retire, status.
// slave:  the ROB itself.
interface rename_rob_if import rob_pkg::*; ();

  logic                alloc_valid;
  logic [2*PREG_W-1:0] alloc_wbs;      // {old_preg, new_preg}
  logic                alloc_ready;
  rob_tag_t            alloc_tag;
  logic                complete_valid;
  rob_tag_t            complete_tag;
  logic                retire_valid;
  preg_t               retire_preg;
  rob_cnt_t            count;
  logic                empty;
  logic                full;

  modport master (
    output alloc_valid, alloc_wbs, complete_valid, complete_tag,
    input  alloc_ready, alloc_tag, retire_valid, retire_preg, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_wbs, complete_valid, complete_tag,
    output alloc_ready, alloc_tag, retire_valid, retire_preg, count, empty, full
  );

endinterface

// File: rtl/rename_rob_wrap_ptr.sv
// Enable-increment pointer, wraps modulo 2**W, synchronous active-high reset.
// Ports: clk, rst, en (advance this edge), ptr (current value).
// Latency: ptr updates one edge after en; no backpressure.
module wrap_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/rename_rob.sv
// In-order ROB behind the renamer: records {old,new} pregs in program order,
// marks entries done out of order, retires the oldest done entry per cycle and
// returns its old_preg to the free pool. Complete at edge E -> pop at E+1 ->
// retire_valid high the cycle after. alloc_ready = !full; a same-edge pop
// does not open a slot.
// Ports: clk, rst (sync, active-high), rif (slave side of rename_rob_if).
module rename_rob import rob_pkg::*; (
  input logic         clk,
  input logic         rst,
  rename_rob_if.slave rif
);

  localparam rob_cnt_t CNT_FULL = rob_cnt_t'(ROB_DEPTH);

  rob_entry_t ent [ROB_DEPTH];
  rob_tag_t   head;
  rob_tag_t   tail;
  rob_cnt_t   count_q;
  logic       alloc_fire;
  logic       pop;

  assign rif.full        = (count_q == CNT_FULL);
  assign rif.empty       = (count_q == '0);
  assign rif.count       = count_q;
  assign rif.alloc_ready = !rif.full;
  assign rif.alloc_tag   = tail;

  assign alloc_fire = rif.alloc_valid && rif.alloc_ready;
  // Uses the registered done bit, so a completion can never pop in the same edge
  assign pop        = ent[head].valid && ent[head].done;

  wrap_ptr #(.W(TAG_W)) u_head (.clk(clk), .rst(rst), .en(pop),        .ptr(head));
  wrap_ptr #(.W(TAG_W)) u_tail (.clk(clk), .rst(rst), .en(alloc_fire), .ptr(tail));

  // Entry array. The slots touched in one edge never collide: alloc writes an
  // invalid slot at tail (not full), pop clears the valid slot at head, and a
  // completion only lands on valid slots, so it cannot hit the tail slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (rif.complete_valid && ent[rif.complete_tag].valid)
        ent[rif.complete_tag].done <= 1'b1;
      if (pop) begin
        ent[head].valid <= 1'b0;
        ent[head].done  <= 1'b0;
      end
      if (alloc_fire) begin
        ent[tail].valid    <= 1'b1;
        ent[tail].done     <= 1'b0;
        ent[tail].old_preg <= rif.alloc_wbs[2*PREG_W-1:PREG_W];
        ent[tail].new_preg <= rif.alloc_wbs[PREG_W-1:0];
      end
    end
  end

  // Retire port; retire_preg holds its last value between retires
  always_ff @(posedge clk) begin
    if (rst) begin
      rif.retire_valid <= 1'b0;
      rif.retire_preg  <= '0;
    end else begin
      rif.retire_valid <= pop;
      if (pop) rif.retire_preg <= ent[head].old_preg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({alloc_fire, pop})
        2'b10:   count_q <= count_q + rob_cnt_t'(1);
        2'b01:   count_q <= count_q - rob_cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rename_rob.sv
// Directed bench for rename_rob: hand-computed expectations for reset,
// single/out-of-order retire, full handling, wrap, full+pop, and reset flush.
module tb_rename_rob;
  import rob_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rename_rob_if rif ();

  rename_rob u_dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    rif.alloc_valid    = 1'b0;
    rif.alloc_wbs      = '0;
    rif.complete_valid = 1'b0;
    rif.complete_tag   = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input int o, input int n);
    rif.alloc_valid = 1'b1;
    rif.alloc_wbs   = {preg_t'(o), preg_t'(n)};
    step();
    rif.alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input int t);
    rif.complete_valid = 1'b1;
    rif.complete_tag   = rob_tag_t'(t);
    step();
    rif.complete_valid = 1'b0;
  endtask

  initial begin
    int nret;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;

    // 1. reset state and single entry round trip
    do_reset();
    chk("rst_retire_valid", int'(rif.retire_valid), 0);
    chk("rst_retire_preg",  int'(rif.retire_preg),  0);
    chk("rst_empty",        int'(rif.empty),        1);
    chk("rst_full",         int'(rif.full),         0);
    chk("rst_alloc_ready",  int'(rif.alloc_ready),  1);
    chk("rst_alloc_tag",    int'(rif.alloc_tag),    0);
    chk("rst_count",        int'(rif.count),        0);
    rif.alloc_valid = 1'b1;
    rif.alloc_wbs   = {preg_t'(3), preg_t'(8)};
    #1 chk("t1_alloc_tag", int'(rif.alloc_tag), 0);
    step();
    rif.alloc_valid = 1'b0;
    chk("t1_count", int'(rif.count), 1);
    do_complete(0);
    chk("t1_ret_E", int'(rif.retire_valid), 0);
    step();
    chk("t1_ret_E1",   int'(rif.retire_valid), 1);
    chk("t1_preg_E1",  int'(rif.retire_preg),  3);
    chk("t1_count_E1", int'(rif.count),        0);
    step();
    chk("t1_ret_E2",  int'(rif.retire_valid), 0);
    chk("t1_preg_E2", int'(rif.retire_preg),  3);

    // 2. out-of-order completion, in-order retire
    do_reset();
    do_alloc(5, 9);
    do_alloc(6, 10);
    do_alloc(7, 11);
    do_complete(2);
    chk("t2_ret_c2", int'(rif.retire_valid), 0);
    do_complete(1);
    chk("t2_ret_c1", int'(rif.retire_valid), 0);
    step();
    chk("t2_ret_idle", int'(rif.retire_valid), 0);
    do_complete(0);
    chk("t2_ret_c0", int'(rif.retire_valid), 0);
    step();
    chk("t2_ret0_v", int'(rif.retire_valid), 1);
    chk("t2_ret0_p", int'(rif.retire_preg),  5);
    step();
    chk("t2_ret1_v", int'(rif.retire_valid), 1);
    chk("t2_ret1_p", int'(rif.retire_preg),  6);
    step();
    chk("t2_ret2_v", int'(rif.retire_valid), 1);
    chk("t2_ret2_p", int'(rif.retire_preg),  7);
    step();
    chk("t2_ret_end", int'(rif.retire_valid), 0);
    chk("t2_empty",   int'(rif.empty),        1);

    // 3. full ROB refuses a 9th alloc; pop clears full
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(i + 1, i + 8);
    chk("t3_full",        int'(rif.full),        1);
    chk("t3_alloc_ready", int'(rif.alloc_ready), 0);
    chk("t3_count",       int'(rif.count),       8);
    do_alloc(15, 15);
    chk("t3_count_drop", int'(rif.count),     8);
    chk("t3_tag_drop",   int'(rif.alloc_tag), 0);
    do_complete(0);
    chk("t3_full_E", int'(rif.full), 1);
    step();
    chk("t3_full_pop",  int'(rif.full),        0);
    chk("t3_count_pop", int'(rif.count),       7);
    chk("t3_preg_pop",  int'(rif.retire_preg), 1);

    // 4. wrap: 12 entries one at a time
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_wbs   = {preg_t'((i % 15) + 1), preg_t'(i)};
      #1 chk("t4_tag", int'(rif.alloc_tag), i % 8);
      step();
      rif.alloc_valid = 1'b0;
      chk("t4_count_a", int'(rif.count), 1);
      do_complete(i % 8);
      chk("t4_count_c", int'(rif.count), 1);
      step();
      chk("t4_count_r", int'(rif.count),        0);
      chk("t4_ret_p",   int'(rif.retire_preg),  (i % 15) + 1);
    end
    chk("t4_empty", int'(rif.empty), 1);

    // 5. full ROB with head done: alloc in the pop edge refused, next accepted
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(i + 1, i + 8);
    do_complete(0);
    rif.alloc_valid = 1'b1;
    rif.alloc_wbs   = {preg_t'(9), preg_t'(9)};
    #1 chk("t5_ready_popcyc", int'(rif.alloc_ready), 0);
    step();
    chk("t5_count_pop", int'(rif.count),        7);
    chk("t5_ret_v",     int'(rif.retire_valid), 1);
    chk("t5_ret_p",     int'(rif.retire_preg),  1);
    chk("t5_ready",     int'(rif.alloc_ready),  1);
    chk("t5_tag",       int'(rif.alloc_tag),    0);
    step();
    rif.alloc_valid = 1'b0;
    chk("t5_count_refill", int'(rif.count),     8);
    chk("t5_full_refill",  int'(rif.full),      1);
    chk("t5_tag_next",     int'(rif.alloc_tag), 1);

    // 6. completion on empty ROB ignored; reset flushes pending entries
    do_reset();
    do_complete(5);
    chk("t6_count_c5", int'(rif.count),        0);
    chk("t6_empty_c5", int'(rif.empty),        1);
    chk("t6_ret_c5",   int'(rif.retire_valid), 0);
    for (int i = 0; i < 6; i++) do_alloc(i + 1, 0);
    nret = 0;
    for (int i = 0; i < 5; i++) begin
      do_complete(i);
      if (rif.retire_valid) nret++;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (rif.retire_valid) nret++;
    end
    chk("t6_retires", nret, 5);
    chk("t6_count_stall", int'(rif.count), 1);
    for (int i = 0; i < 3; i++) do_alloc(10 + i, 0);
    chk("t6_count_pend", int'(rif.count), 4);
    do_complete(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_count", int'(rif.count),        0);
    chk("t6_rst_ret",   int'(rif.retire_valid), 0);
    chk("t6_rst_empty", int'(rif.empty),        1);
    nret = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rif.retire_valid) nret++;
    end
    chk("t6_no_stray", nret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
